// File: rtl/branch_predictor.sv
// BTB + gshare predictor: combinational (zero-latency) next-PC lookup, trained on the edge after EX resolves.
// No backpressure: one update accepted per cycle unconditionally; lookups see pre-update state.
module branch_predictor #(
  parameter int ENTRIES  = 32,
  parameter int IDX_BITS = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [31:0]         IF_pc,
  output logic [31:0]         pc_BTB,
  output logic                pred_taken,
  output logic [IDX_BITS-1:0] pred_index,
  input  logic                update_valid,
  input  logic [31:0]         update_pc,
  input  logic                update_is_branch,
  input  logic                update_taken,
  input  logic [31:0]         update_target,
  input  logic [IDX_BITS-1:0] update_index
);

  localparam int TAG_BITS = 32 - IDX_BITS - 2;

  logic [ENTRIES-1:0]  valid_q;
  logic [ENTRIES-1:0]  is_jump_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          pht_q    [ENTRIES];
  logic [IDX_BITS-1:0] ghr_q;

  logic [IDX_BITS-1:0] if_bi;
  logic [TAG_BITS-1:0] if_tag;
  logic [IDX_BITS-1:0] upd_bi;
  logic [TAG_BITS-1:0] upd_tag;
  logic                hit;
  logic [1:0]          unused_pc_lsb;

  assign if_bi         = IF_pc[IDX_BITS+1:2];
  assign if_tag        = IF_pc[31:IDX_BITS+2];
  assign upd_bi        = update_pc[IDX_BITS+1:2];
  assign upd_tag       = update_pc[31:IDX_BITS+2];
  assign unused_pc_lsb = update_pc[1:0];

  // Reset clears valid and GHR asynchronously, so the lookup falls back to
  // the sequential path without any extra gating.
  assign pred_index = if_bi ^ ghr_q;
  assign hit        = valid_q[if_bi] && (tag_q[if_bi] == if_tag);
  assign pred_taken = hit && (is_jump_q[if_bi] || pht_q[pred_index][1]);
  assign pc_BTB     = pred_taken ? target_q[if_bi] : IF_pc + 32'd4;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= '0;
      is_jump_q <= '0;
      ghr_q     <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        pht_q[i] <= 2'b01;
      end
    end else if (update_valid) begin
      if (update_taken) begin
        valid_q[upd_bi]   <= 1'b1;
        is_jump_q[upd_bi] <= ~update_is_branch;
      end
      if (update_is_branch) begin
        if (update_taken && pht_q[update_index] != 2'b11) begin
          pht_q[update_index] <= pht_q[update_index] + 2'd1;
        end else if (!update_taken && pht_q[update_index] != 2'b00) begin
          pht_q[update_index] <= pht_q[update_index] - 2'd1;
        end
        ghr_q <= {ghr_q[IDX_BITS-2:0], update_taken};
      end
    end
  end

  // Tag/target payload is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (update_valid && update_taken) begin
      tag_q[upd_bi]    <= upd_tag;
      target_q[upd_bi] <= update_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized + directed bench for branch_predictor against a behavioural array model.
module tb_branch_predictor;
  localparam int ENTRIES = 32;
  localparam int IB      = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [31:0]   IF_pc;
  logic [31:0]   pc_BTB;
  logic          pred_taken;
  logic [IB-1:0] pred_index;
  logic          update_valid;
  logic [31:0]   update_pc;
  logic          update_is_branch;
  logic          update_taken;
  logic [31:0]   update_target;
  logic [IB-1:0] update_index;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .reset_n(reset_n), .IF_pc(IF_pc), .pc_BTB(pc_BTB),
    .pred_taken(pred_taken), .pred_index(pred_index),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_is_branch(update_is_branch), .update_taken(update_taken),
    .update_target(update_target), .update_index(update_index)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Behavioural model: plain arrays, counters kept as integers 0..3.
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  bit          m_jump   [ENTRIES];
  int          m_pht    [ENTRIES];
  int unsigned m_ghr;

  logic [31:0] obs_pc;
  logic        obs_tk;
  logic [31:0] obs_idx;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc >> 2) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> (IB + 2);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_pht[i]   = 1;
    end
    m_ghr = 0;
  endfunction

  function automatic void model_update(input logic [31:0] pc, input bit br, input bit tk,
                                       input logic [31:0] tgt, input int unsigned uidx);
    int unsigned bi;
    bi = idx_of(pc);
    if (tk) begin
      m_valid[bi]  = 1'b1;
      m_tag[bi]    = tag_of(pc);
      m_target[bi] = tgt;
      m_jump[bi]   = !br;
    end
    if (br) begin
      if (tk) m_pht[uidx] = (m_pht[uidx] == 3) ? 3 : m_pht[uidx] + 1;
      else    m_pht[uidx] = (m_pht[uidx] == 0) ? 0 : m_pht[uidx] - 1;
      m_ghr = ((m_ghr << 1) | (tk ? 1 : 0)) % ENTRIES;
    end
  endfunction

  task automatic check_lookup(input string tag);
    int unsigned bi, pidx;
    bit          hit, tk;
    logic [31:0] exp_pc;
    bi     = idx_of(IF_pc);
    pidx   = bi ^ m_ghr;
    hit    = m_valid[bi] && (m_tag[bi] == tag_of(IF_pc));
    tk     = hit && (m_jump[bi] || m_pht[pidx] >= 2);
    exp_pc = tk ? m_target[bi] : IF_pc + 32'd4;
    obs_pc  = pc_BTB;
    obs_tk  = pred_taken;
    obs_idx = 32'(pred_index);
    check({tag, "/pc_BTB"}, pc_BTB, exp_pc);
    check({tag, "/taken"}, 32'(pred_taken), 32'(tk));
    check({tag, "/index"}, 32'(pred_index), pidx);
  endtask

  // One cycle: drive lookup + update, check lookup at negedge (pre-update), clock it in.
  task automatic do_cycle(input string tag, input logic [31:0] pc, input bit uv,
                          input logic [31:0] upc, input bit br, input bit tk,
                          input logic [31:0] tgt, input int unsigned uidx);
    IF_pc            = pc;
    update_valid     = uv;
    update_pc        = upc;
    update_is_branch = br;
    update_taken     = tk;
    update_target    = tgt;
    update_index     = IB'(uidx);
    @(negedge clk);
    check_lookup(tag);
    @(posedge clk);
    if (uv) model_update(upc, br, tk, tgt, uidx);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc);
    do_cycle(tag, pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 0);
  endtask

  task automatic upd(input logic [31:0] upc, input bit br, input bit tk,
                     input logic [31:0] tgt, input int unsigned uidx);
    do_cycle("upd", 32'h100, 1'b1, upc, br, tk, tgt, uidx);
  endtask

  // Shift 1,0,1,0,1 into the history via branches on an unrelated PHT slot.
  task automatic shape_ghr_21();
    for (int i = 0; i < 5; i++) upd(32'h1000, 1'b1, (i % 2) == 0, 32'h2000, 20);
  endtask

  initial begin
    reset_n = 1'b0;
    IF_pc = 32'h100; update_valid = 1'b0; update_pc = '0; update_is_branch = 1'b0;
    update_taken = 1'b0; update_target = '0; update_index = '0;
    model_reset();
    #12;
    check_lookup("reset");
    check("reset_pc", obs_pc, 32'h104);
    check("reset_tk", 32'(obs_tk), 32'd0);
    check("reset_idx", obs_idx, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // JAL: same-cycle lookup sees old state, next cycle hits.
    do_cycle("jal_same", 32'h20, 1'b1, 32'h20, 1'b0, 1'b1, 32'h80, 0);
    check("jal_nobypass", obs_pc, 32'h24);
    look("jal_hit", 32'h20);
    check("jal_pc", obs_pc, 32'h80);
    check("jal_tk", 32'(obs_tk), 32'd1);
    check("jal_ghr0", obs_idx, 32'd8);

    // Branch at 0x40 training PHT[5]: T,T,T,NT -> weak taken.
    for (int i = 0; i < 3; i++) upd(32'h40, 1'b1, 1'b1, 32'h10, 5);
    upd(32'h40, 1'b1, 1'b0, 32'h10, 5);
    shape_ghr_21();
    look("br_wt", 32'h40);
    check("br_wt_idx", obs_idx, 32'd5);
    check("br_wt_pc", obs_pc, 32'h10);
    upd(32'h40, 1'b1, 1'b1, 32'h10, 5);
    upd(32'h40, 1'b1, 1'b0, 32'h10, 5);
    upd(32'h40, 1'b1, 1'b0, 32'h10, 5);
    shape_ghr_21();
    look("br_wnt", 32'h40);
    check("br_wnt_idx", obs_idx, 32'd5);
    check("br_wnt_pc", obs_pc, 32'h44);

    // Not-taken branch never allocates.
    upd(32'h60, 1'b1, 1'b0, 32'h400, 3);
    look("nt_noalloc", 32'h60);
    check("nt_pc", obs_pc, 32'h64);

    // Aliasing at BTB index 1.
    upd(32'h04, 1'b0, 1'b1, 32'h200, 0);
    upd(32'h84, 1'b0, 1'b1, 32'h300, 0);
    look("alias_old", 32'h04);
    check("alias_old_pc", obs_pc, 32'h08);
    look("alias_new", 32'h84);
    check("alias_new_pc", obs_pc, 32'h300);

    // Asynchronous reset mid-cycle.
    IF_pc = 32'h20;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_lookup("async_rst");
    check("async_rst_pc", obs_pc, 32'h24);
    check("async_rst_tk", 32'(obs_tk), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    look("post_rst", 32'h20);
    check("post_rst_pc", obs_pc, 32'h24);

    // Randomized traffic over a small PC pool to force hits and aliasing.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] lpc, upc, tgt;
      bit          uv, br, tk;
      lpc = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2);
      upc = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2);
      if (($urandom % 50) == 0) upc = 32'hFFFF_FFFC;
      if (($urandom % 50) == 0) lpc = 32'hFFFF_FFFC;
      uv  = ($urandom % 10) < 7;
      br  = $urandom % 2;
      tk  = br ? bit'($urandom % 2) : 1'b1;
      tgt = $urandom & 32'hFFFF_FFFC;
      do_cycle("rand", lpc, uv, upc, br, tk, tgt, $urandom_range(0, ENTRIES - 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Branch target buffer and gshare direction predictor for the five-stage pipelined core. It supplies the fetch stage with a predicted next PC (`pc_BTB`) every cycle, looked up combinationally from the current fetch PC. It is trained one cycle after the EX stage resolves a control-flow instruction (JAL, JALR, BRANCH). The branch hazard logic still owns misprediction detection and flushing; this block only stores and updates prediction state.

## Interface
Parameters:
- `ENTRIES`, 32, number of BTB entries and PHT counters; power of two, 4..256.
- `IDX_BITS`, $clog2(ENTRIES), index width; also the global history length.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `IF_pc`  in  32  fetch-stage PC.
- `pc_BTB`  out  32  predicted next fetch PC.
- `pred_taken`  out  1  prediction redirects fetch (`pc_BTB` != `IF_pc`+4 path).
- `pred_index`  out  IDX_BITS  PHT index used for this lookup; the pipeline carries it to EX.
- `update_valid`  in  1  EX resolves a control instruction this cycle.
- `update_pc`  in  32  PC of the resolving instruction (ID_EX_pc).
- `update_is_branch`  in  1  1 = conditional BRANCH, 0 = JAL/JALR.
- `update_taken`  in  1  actual outcome; always 1 for JAL/JALR.
- `update_target`  in  32  resolved target (pc+imm or ALU result for JALR).
- `update_index`  in  IDX_BITS  `pred_index` carried with the instruction.

## Operation
- BTB index `bi` = pc[IDX_BITS+1:2]. Tag = pc[31:IDX_BITS+2].
- Each BTB entry holds: valid, tag, target[31:0], is_jump.
- PHT holds ENTRIES 2-bit saturating counters. Values: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- GHR is an IDX_BITS shift register. It is non-speculative: it changes only on resolution.
- Lookup (combinational):
  - `pred_index` = IF_pc[IDX_BITS+1:2] ^ GHR.
  - hit = valid[bi] && tag[bi] == IF_pc tag.
  - `pred_taken` = hit && (is_jump[bi] || PHT[pred_index][1]).
  - `pc_BTB` = `pred_taken` ? target[bi] : IF_pc + 4. The +4 wraps modulo 2^32.
- Update (rising edge, when `update_valid`=1):
  - BTB:
    - If `update_taken`, write entry `bi`(update_pc): valid=1, tag, target=`update_target`, is_jump=~`update_is_branch`. This unconditionally replaces any aliasing entry.
    - If not taken, the BTB is unchanged; a not-taken branch never allocates.
  - PHT, only if `update_is_branch`: the counter at `update_index` increments if taken, else decrements. It saturates at 11 and 00.
  - GHR, only if `update_is_branch`: GHR <= {GHR[IDX_BITS-2:0], `update_taken`}.
  - JAL/JALR never touch the PHT or GHR.
- `update_valid`=0: no state changes; all update inputs are ignored.

## Timing
- Lookup is zero latency, purely combinational from `IF_pc` and stored state.
- Update is visible to a lookup in the cycle after the edge that writes it.
- Same-cycle lookup and update of the same entry: the lookup returns the pre-update value. There is no write-through bypass.
- Reset (`reset_n`=0), asynchronous and immediate, including mid-operation:
  - all valid=0, all PHT counters=01, GHR=0.
  - Outputs while in reset: `pred_taken`=0, `pc_BTB`=IF_pc+4, `pred_index`=IF_pc[IDX_BITS+1:2].
  - Tag and target contents need not be reset.
- Deassertion of `reset_n` is synchronised externally. The first update is accepted on the first rising edge with `reset_n`=1.
- No stalls or handshakes. The block accepts one update per cycle unconditionally.

## Test plan
- Reset, `IF_pc`=0x100 -> `pc_BTB`=0x104, `pred_taken`=0, `pred_index`=0 (ENTRIES=32).
- Update JAL: pc=0x20, target=0x80, taken=1. Next cycle `IF_pc`=0x20 -> `pc_BTB`=0x80, `pred_taken`=1. GHR stays 0.
- Branch: pc=0x40, target=0x10, `update_index`=5, taken 3 times -> PHT[5]=11. Then one not-taken -> PHT[5]=10. With GHR forced via history so `pred_index`=5, lookup predicts 0x10. A fourth taken then two more not-taken -> PHT[5]=01, and lookup gives 0x44.
- Not-taken branch at 0x60 with no prior entry -> BTB unchanged, `pc_BTB`=0x64. GHR shifts to {prev,0}.
- Aliasing: taken JAL at 0x04 (target 0x200), then taken JAL at 0x84 (target 0x300), same index 1. Lookup 0x04 -> 0x08 (miss); lookup 0x84 -> 0x300.
- Assert `reset_n`=0 mid-cycle after training -> outputs revert to miss immediately, without waiting for a clock edge. After release, `IF_pc`=0x20 -> 0x24.
